// File: rtl/stream_demux_if.sv
// Ingress stream plus per-channel egress handshake bundle for stream_demux.
// master = producer/consumer side, slave = the demux itself.
interface stream_demux_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT)
);
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1:NUM_OUT valid/ready demux with one-entry buffer per channel.
// Optional saturating drop counter for out-of-range selects: STREAM_DEMUX_DROP_CNT_EN.
module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [SEL_W:0] NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);

  logic [NUM_OUT-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_OUT-1:0]             valid_q, valid_d;
  logic [NUM_OUT-1:0]             sel_hit;
  logic [NUM_OUT-1:0]             slot_free;
  logic                           in_range;
  logic                           in_fire;

  assign in_range = ({1'b0, bus.in_sel} < NUM_OUT_EXT);

  // Per-channel decode keeps out-of-range selects from ever indexing channel state.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chan
    assign sel_hit[gi]   = in_range && (bus.in_sel == SEL_W'(gi));
    assign slot_free[gi] = !valid_q[gi] || bus.out_ready[gi];
    assign valid_d[gi]   = (in_fire && sel_hit[gi]) || (valid_q[gi] && !bus.out_ready[gi]);
    assign data_d[gi]    = (in_fire && sel_hit[gi]) ? bus.in_data : data_q[gi];
  end

  assign bus.in_ready  = !in_range || |(sel_hit & slot_free);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_fire && !in_range && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: vector table on a 4-channel instance,
// hand sequences for async reset and out-of-range drops on a 3-channel instance.
module tb_stream_demux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(8), .NUM_OUT(4)) if4 ();
  stream_demux_if #(.DATA_W(8), .NUM_OUT(3)) if3 ();

  logic [15:0] drop_cnt4;
  logic [1:0]  drop_cnt3;

  stream_demux #(.DATA_W(8), .NUM_OUT(4), .CNT_W(16)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if4.slave),
    .drop_cnt (drop_cnt4)
  );

  stream_demux #(.DATA_W(8), .NUM_OUT(3), .CNT_W(2)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if3.slave),
    .drop_cnt (drop_cnt3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic        valid;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int exp_drop;

    if4.in_data = '0; if4.in_sel = '0; if4.in_valid = 1'b0; if4.out_ready = '0;
    if3.in_data = '0; if3.in_sel = '0; if3.in_valid = 1'b0; if3.out_ready = '0;

    // sel, data, valid, out_ready, exp in_ready, exp out_valid, exp out_data {ch3,ch2,ch1,ch0}
    vecs.push_back('{2'd0, 8'h11, 1'b1, 4'hF, 1'b1, 4'b0001, 32'h00_00_00_11});
    vecs.push_back('{2'd1, 8'h22, 1'b1, 4'hF, 1'b1, 4'b0010, 32'h00_00_22_11});
    vecs.push_back('{2'd2, 8'h33, 1'b1, 4'hF, 1'b1, 4'b0100, 32'h00_33_22_11});
    vecs.push_back('{2'd3, 8'h44, 1'b1, 4'hF, 1'b1, 4'b1000, 32'h44_33_22_11});
    vecs.push_back('{2'd1, 8'hAA, 1'b1, 4'hD, 1'b1, 4'b0010, 32'h44_33_AA_11});
    vecs.push_back('{2'd1, 8'hBB, 1'b1, 4'hD, 1'b0, 4'b0010, 32'h44_33_AA_11});
    vecs.push_back('{2'd3, 8'hCC, 1'b1, 4'hD, 1'b1, 4'b1010, 32'hCC_33_AA_11});
    vecs.push_back('{2'd1, 8'hBB, 1'b1, 4'hF, 1'b1, 4'b0010, 32'hCC_33_BB_11});
    vecs.push_back('{2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'hCC_33_BB_11});
    for (int k = 0; k < 8; k++) begin
      vecs.push_back('{2'd0, 8'(k), 1'b1, 4'hF, 1'b1, 4'b0001, {24'hCC_33_BB, 8'(k)}});
    end
    vecs.push_back('{2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 32'hCC_33_BB_07});
    vecs.push_back('{2'd2, 8'h5A, 1'b1, 4'h0, 1'b1, 4'b0100, 32'hCC_5A_BB_07});
    vecs.push_back('{2'd2, 8'h77, 1'b0, 4'h0, 1'b0, 4'b0100, 32'hCC_5A_BB_07});
    vecs.push_back('{2'd0, 8'h66, 1'b1, 4'h0, 1'b1, 4'b0101, 32'hCC_5A_BB_66});
    vecs.push_back('{2'd2, 8'hA5, 1'b1, 4'hF, 1'b1, 4'b0100, 32'hCC_A5_BB_66});

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 32'(if4.out_valid), 32'h0);
    check("reset_out_data", if4.out_data, 32'h0);
    check("reset_drop_cnt", 32'(drop_cnt4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if4.in_sel    = vecs[i].sel;
      if4.in_data   = vecs[i].data;
      if4.in_valid  = vecs[i].valid;
      if4.out_ready = vecs[i].ordy;
      #1;
      $display("vec %0d: sel=%0d data=%h valid=%b out_ready=%b in_ready=%b",
               i, vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ordy, if4.in_ready);
      check($sformatf("v%0d_in_ready", i), 32'(if4.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(if4.out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_out_data", i), if4.out_data, vecs[i].exp_od);
    end

    // Async reset mid-cycle while channel 2 holds A5.
    @(negedge clk);
    if4.in_valid  = 1'b0;
    if4.out_ready = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    check("async_rst_out_valid", 32'(if4.out_valid), 32'h0);
    check("async_rst_out_data", if4.out_data, 32'h0);
    check("async_rst_drop_cnt", 32'(drop_cnt4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    if4.in_sel = 2'd2;
    #1;
    check("post_rst_in_ready", 32'(if4.in_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(if4.out_valid), 32'h0);

    // Out-of-range selects on the 3-channel instance.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if3.in_sel    = 2'd3;
      if3.in_data   = 8'hE0 + 8'(k);
      if3.in_valid  = 1'b1;
      if3.out_ready = 3'b111;
      #1;
      check($sformatf("oor%0d_in_ready", k), 32'(if3.in_ready), 32'h1);
      @(posedge clk);
      #1;
`ifdef STREAM_DEMUX_DROP_CNT_EN
      exp_drop = (k + 1 > 3) ? 3 : k + 1;
`else
      exp_drop = 0;
`endif
      $display("oor beat %0d: out_valid=%b drop_cnt=%0d", k, if3.out_valid, drop_cnt3);
      check($sformatf("oor%0d_out_valid", k), 32'(if3.out_valid), 32'h0);
      check($sformatf("oor%0d_drop_cnt", k), 32'(drop_cnt3), 32'(exp_drop));
    end

    // In-range beat on the 3-channel instance still steers normally.
    @(negedge clk);
    if3.in_sel  = 2'd1;
    if3.in_data = 8'h3C;
    @(posedge clk);
    #1;
    $display("n3 beat sel=1 data=3c: out_valid=%b", if3.out_valid);
    check("n3_out_valid", 32'(if3.out_valid), 32'h2);
    check("n3_out_data", 32'(if3.out_data), 32'h00_3C_00);
    @(negedge clk);
    if3.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
